// File: rtl/mem_bus_pkg.sv
// Shared definitions for the C2/D2/A2 line bus: command codes, widths,
// initiator state encoding and line/beat packing helpers.
package mem_bus_pkg;

    localparam int CACHE_OFFSET_SIZE = 4;
    localparam int ADDR_LINE_W       = 15;
    localparam int DATA_W            = 16;
    localparam int LINE_BYTES        = 1 << CACHE_OFFSET_SIZE;
    localparam int LINE_W            = LINE_BYTES * 8;

    // C2 command encoding
    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_HOLD,
        ST_DONE
    } bus_state_e;

    typedef logic [DATA_W-1:0] beat_t;
    typedef logic [LINE_W-1:0] line_t;

    // Beat idx carries line byte 2*idx in its upper half and byte 2*idx+1 in its lower half.
    function automatic beat_t get_beat(input line_t l, input logic [2:0] idx);
        return {l[{idx, 4'd0} +: 8], l[{idx, 4'd8} +: 8]};
    endfunction

    function automatic line_t put_beat(input line_t l, input logic [2:0] idx, input beat_t b);
        line_t r;
        r = l;
        r[{idx, 4'd0} +: 8] = b[15:8];
        r[{idx, 4'd8} +: 8] = b[7:0];
        return r;
    endfunction

endpackage

// File: rtl/bus_tristate_drv.sv
// Output-enable buffer for one shared bus field; the only place the
// initiator drives Z onto C2, A2 or D2.
module bus_tristate_drv #(
    parameter int W = 1
) (
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output wire  [W-1:0] bus_o
);

    assign bus_o = en_i ? data_i : {W{1'bz}};

endmodule

// File: rtl/mem_bus_initiator.sv
// Cache-side master of the C2/D2/A2 line bus. Moves one 16-byte line per
// request as 8 beats of 16 bits and owns bus turnaround during reads.
//
// Request handshake: a request is accepted on a clk edge where
// req_valid && req_ready; req_ready is high only in IDLE, the requester
// holds req_valid and its fields stable until then, and completion is a
// single-cycle resp_valid pulse with resp_err (and resp_rdata on reads).
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int LINE_BEATS     = 8,
    parameter int WR_BUSY_CYCLES = 100,
    parameter int RD_TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [ADDR_LINE_W-1:0] req_line,
    input  logic [LINE_W-1:0]      req_wdata,
    output logic                   req_ready,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [LINE_W-1:0]      resp_rdata,
    output wire  [ADDR_LINE_W-1:0] A2,
    inout  wire  [DATA_W-1:0]      D2,
    inout  wire  [1:0]             C2,
    output bus_state_e             dbg_state_o
);

    localparam int         WAIT_W    = $clog2(RD_TIMEOUT + 1);
    localparam int         HOLD_W    = $clog2(WR_BUSY_CYCLES + 1);
    localparam logic [2:0] LAST_BEAT = 3'(LINE_BEATS - 1);

    bus_state_e             state_q, state_d;
    logic [ADDR_LINE_W-1:0] line_q, line_d;
    line_t                  buf_q, buf_d;
    line_t                  rdata_q, rdata_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   err_q, err_d;

    logic                   c2_en, a2_en, d2_en;
    logic [1:0]             c2_val;
    beat_t                  d2_val;

    // State and datapath registers; reset drops any transfer in flight.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counters and bus drive enables for the line transfer FSM.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        hold_d  = hold_q;
        err_d   = err_q;
        c2_en   = 1'b1;
        c2_val  = C2_NOP;
        a2_en   = 1'b0;
        d2_en   = 1'b0;
        d2_val  = get_beat(buf_q, cnt_q);

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    line_d  = req_line;
                    buf_d   = req_wdata;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    wait_d  = '0;
                    hold_d  = '0;
                    state_d = req_write ? ST_WR_DATA : ST_RD_CMD;
                end
            end
            ST_RD_CMD: begin
                c2_val  = C2_READ_LINE;
                a2_en   = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // Bus is handed to memory; a response wins over a timeout in the same cycle.
                c2_en  = 1'b0;
                wait_d = wait_q + 1'b1;
                if (C2 == C2_RESPONSE) begin
                    buf_d   = put_beat(buf_q, 3'd0, D2);
                    cnt_d   = 3'd1;
                    state_d = ST_RD_DATA;
                end else if (wait_d == WAIT_W'(RD_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_DATA: begin
                c2_en = 1'b0;
                buf_d = put_beat(buf_q, cnt_q, D2);
                if (cnt_q == LAST_BEAT) begin
                    rdata_d = buf_d;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WR_DATA: begin
                c2_val = (cnt_q == 3'd0) ? C2_WRITE_LINE : C2_NOP;
                a2_en  = 1'b1;
                d2_en  = 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WR_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_d == HOLD_W'(WR_BUSY_CYCLES)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_DONE);
    assign resp_err    = (state_q == ST_DONE) && err_q;
    assign resp_rdata  = rdata_q;
    assign dbg_state_o = state_q;

    bus_tristate_drv #(.W(2)) u_c2_drv (
        .en_i   (c2_en),
        .data_i (c2_val),
        .bus_o  (C2)
    );

    bus_tristate_drv #(.W(ADDR_LINE_W)) u_a2_drv (
        .en_i   (a2_en),
        .data_i (line_q),
        .bus_o  (A2)
    );

    bus_tristate_drv #(.W(DATA_W)) u_d2_drv (
        .en_i   (d2_en),
        .data_i (d2_val),
        .bus_o  (D2)
    );

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Bench for mem_bus_initiator: scenario tasks with a behavioural memory
// model. Bus lines carry pull-ups so a released field reads as all ones.
module tb_mem_bus_initiator;
    import mem_bus_pkg::*;

    localparam int WR_BUSY = 100;
    localparam int RD_TO   = 255;
    localparam logic [1:0]  REL_C2 = 2'b11;
    localparam logic [14:0] REL_A2 = 15'h7FFF;
    localparam logic [15:0] REL_D2 = 16'hFFFF;

    logic         clk;
    logic         RESET;
    logic         req_valid;
    logic         req_write;
    logic [14:0]  req_line;
    logic [127:0] req_wdata;
    logic         req_ready;
    logic         resp_valid;
    logic         resp_err;
    logic [127:0] resp_rdata;
    wire  [14:0]  A2;
    wire  [15:0]  D2;
    wire  [1:0]   C2;
    bus_state_e   dbg_state;

    logic         mem_en;
    logic [15:0]  mem_d;
    int           mem_delay;
    logic [127:0] mem_line;

    int           n_tests;
    int           n_fail;
    logic [128:0] exp_q[$];
    logic [127:0] model_rdata;

    assign D2 = mem_en ? mem_d : 16'bz;
    assign C2 = mem_en ? C2_RESPONSE : 2'bz;

    for (genvar g = 0; g < 16; g++) begin : g_pu_d2
        pullup (D2[g]);
    end
    for (genvar g = 0; g < 15; g++) begin : g_pu_a2
        pullup (A2[g]);
    end
    for (genvar g = 0; g < 2; g++) begin : g_pu_c2
        pullup (C2[g]);
    end

    mem_bus_initiator dut (
        .clk         (clk),
        .RESET       (RESET),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_line    (req_line),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_err    (resp_err),
        .resp_rdata  (resp_rdata),
        .A2          (A2),
        .D2          (D2),
        .C2          (C2),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus beat i = {line byte 2i, line byte 2i+1}
    function automatic logic [15:0] line_beat(input logic [127:0] l, input int i);
        return {l[16*i +: 8], l[16*i+8 +: 8]};
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory controller model: after seeing READ_LINE, answer in wait cycle mem_delay (0 = never).
    initial begin
        mem_en = 1'b0;
        mem_d  = '0;
        forever begin
            @(negedge clk);
            if (C2 === C2_READ_LINE && RESET === 1'b0 && mem_delay > 0) begin
                repeat (mem_delay) @(posedge clk);
                for (int i = 0; i < 8; i++) begin
                    #1;
                    mem_en = 1'b1;
                    mem_d  = line_beat(mem_line, i);
                    @(posedge clk);
                end
                #1;
                mem_en = 1'b0;
            end
        end
    end

    // Present a request in IDLE; returns at the first negedge after the accepting edge.
    task automatic issue(input logic wr, input logic [14:0] line, input logic [127:0] data);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: req_ready=%b, required 1", req_ready);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_line  = line;
        req_wdata = data;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_read(input string tag, input logic [14:0] line, input int delay,
                            input logic [127:0] mline);
        int           cyc;
        int           resp_cyc;
        int           bus_bad;
        int           exp_cyc;
        logic         exp_err;
        logic [128:0] exp;
        mem_delay = delay;
        mem_line  = mline;
        exp_err   = (delay == 0);
        exp_cyc   = exp_err ? (1 + RD_TO + 1) : (1 + delay + 8);
        if (!exp_err) model_rdata = mline;
        exp_q.push_back({exp_err, model_rdata});
        issue(1'b0, line, rand_line());
        n_tests++;
        if (C2 !== C2_READ_LINE || A2 !== line) begin
            n_fail++;
            $display("FAIL %s_cmd: C2=%h A2=%h, required C2=%h A2=%h", tag, C2, A2, C2_READ_LINE, line);
        end
        cyc      = 1;
        resp_cyc = -1;
        bus_bad  = 0;
        while (resp_cyc < 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (resp_valid === 1'b1) begin
                resp_cyc = cyc;
            end else if (!exp_err && cyc >= delay + 1 && cyc <= delay + 8) begin
                if (C2 !== C2_RESPONSE || D2 !== line_beat(mline, cyc - delay - 1) || A2 !== REL_A2)
                    bus_bad++;
            end else if (C2 !== REL_C2 || D2 !== REL_D2 || A2 !== REL_A2) begin
                bus_bad++;
            end
        end
        n_tests++;
        if (resp_cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s_latency: resp at cycle %0d, required %0d", tag, resp_cyc, exp_cyc);
        end
        n_tests++;
        if (bus_bad != 0) begin
            n_fail++;
            $display("FAIL %s_turnaround: %0d cycles with bus not released, required 0", tag, bus_bad);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if (resp_err !== exp[128] || resp_rdata !== exp[127:0]) begin
            n_fail++;
            $display("FAIL %s_resp: err=%b rdata=%h, required err=%b rdata=%h",
                     tag, resp_err, resp_rdata, exp[128], exp[127:0]);
        end
        n_tests++;
        if (C2 !== C2_NOP) begin
            n_fail++;
            $display("FAIL %s_done_c2: C2=%h, required %h", tag, C2, C2_NOP);
        end
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_after: resp_valid=%b req_ready=%b, required 0/1", tag, resp_valid, req_ready);
        end
    endtask

    task automatic run_write(input string tag, input logic [14:0] line, input logic [127:0] data);
        int           cyc;
        int           resp_cyc;
        int           hold_bad;
        logic [1:0]   exp_c2;
        logic [128:0] exp;
        mem_delay = 0;
        exp_q.push_back({1'b0, model_rdata});
        issue(1'b1, line, data);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            exp_c2 = (i == 0) ? C2_WRITE_LINE : C2_NOP;
            n_tests++;
            if (C2 !== exp_c2 || A2 !== line || D2 !== line_beat(data, i)) begin
                n_fail++;
                $display("FAIL %s_beat%0d: C2=%h A2=%h D2=%h, required C2=%h A2=%h D2=%h",
                         tag, i, C2, A2, D2, exp_c2, line, line_beat(data, i));
            end
        end
        cyc      = 8;
        resp_cyc = -1;
        hold_bad = 0;
        while (resp_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (resp_valid === 1'b1) resp_cyc = cyc;
            else if (C2 !== C2_NOP || A2 !== REL_A2 || D2 !== REL_D2) hold_bad++;
        end
        n_tests++;
        if (resp_cyc != 1 + 8 + WR_BUSY) begin
            n_fail++;
            $display("FAIL %s_latency: resp at cycle %0d, required %0d", tag, resp_cyc, 1 + 8 + WR_BUSY);
        end
        n_tests++;
        if (hold_bad != 0) begin
            n_fail++;
            $display("FAIL %s_hold_bus: %0d bad hold cycles, required 0", tag, hold_bad);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        n_tests++;
        if (resp_err !== exp[128] || resp_rdata !== exp[127:0]) begin
            n_fail++;
            $display("FAIL %s_resp: err=%b rdata=%h, required err=%b rdata=%h",
                     tag, resp_err, resp_rdata, exp[128], exp[127:0]);
        end
        @(negedge clk);
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_after: resp_valid=%b req_ready=%b, required 0/1", tag, resp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        model_rdata = '0;
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b valid=%b err=%b, required 1/0/0", req_ready, resp_valid, resp_err);
        end
        n_tests++;
        if (resp_rdata !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: %h, required 0", resp_rdata);
        end
        n_tests++;
        if (C2 !== C2_NOP || A2 !== REL_A2 || D2 !== REL_D2) begin
            n_fail++;
            $display("FAIL reset_bus: C2=%h A2=%h D2=%h, required %h/%h/%h", C2, A2, D2, C2_NOP, REL_A2, REL_D2);
        end
        RESET = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        logic [127:0] ml;
        for (int k = 0; k < 16; k++) ml[8*k +: 8] = 8'(k + 1);
        run_read("read100", 15'h0003, 100, ml);
        run_read("read_min", 15'h1234, 1, rand_line());
    endtask

    task automatic test_write();
        logic [127:0] wd;
        for (int k = 0; k < 16; k++) wd[8*k +: 8] = 8'(k);
        run_write("write", 15'h7FFF, wd);
    endtask

    task automatic test_timeout();
        run_read("timeout", 15'h0155, 0, rand_line());
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            if ($urandom_range(0, 1) == 1)
                run_write("rnd_wr", 15'($urandom), rand_line());
            else
                run_read("rnd_rd", 15'($urandom), $urandom_range(1, 60), rand_line());
        end
    endtask

    task automatic test_back_to_back();
        int           d;
        int           cyc;
        int           ready_cyc;
        bit           drop_next;
        int           pulses[$];
        logic [127:0] ml;
        logic [127:0] first_rdata;
        logic         first_err;
        logic [1:0]   c2_second;
        d         = $urandom_range(10, 40);
        ml        = rand_line();
        mem_delay = d;
        mem_line  = ml;
        model_rdata = ml;
        while (req_ready !== 1'b1) @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_line  = 15'h0042;
        req_wdata = rand_line();
        @(negedge clk);
        // Second request is held while the read is in flight.
        req_write   = 1'b1;
        req_line    = 15'h0777;
        req_wdata   = rand_line();
        cyc         = 1;
        ready_cyc   = -1;
        drop_next   = 1'b0;
        first_rdata = '0;
        first_err   = 1'b1;
        c2_second   = 2'bxx;
        while (cyc < d + 130) begin
            @(negedge clk);
            cyc++;
            if (drop_next) begin
                req_valid = 1'b0;
                drop_next = 1'b0;
            end
            if (cyc == d + 11) c2_second = C2;
            if (resp_valid === 1'b1) begin
                pulses.push_back(cyc);
                if (pulses.size() == 1) begin
                    first_rdata = resp_rdata;
                    first_err   = resp_err;
                end
            end
            if (req_ready === 1'b1 && ready_cyc < 0) begin
                ready_cyc = cyc;
                drop_next = 1'b1;
            end
        end
        n_tests++;
        if (ready_cyc != d + 10) begin
            n_fail++;
            $display("FAIL bp_accept: ready at cycle %0d, required %0d", ready_cyc, d + 10);
        end
        n_tests++;
        if (pulses.size() != 2) begin
            n_fail++;
            $display("FAIL bp_pulses: %0d pulses, required 2", pulses.size());
        end else begin
            n_tests++;
            if (pulses[0] != d + 9 || pulses[1] != d + 119) begin
                n_fail++;
                $display("FAIL bp_pulse_cycles: %0d,%0d, required %0d,%0d", pulses[0], pulses[1], d + 9, d + 119);
            end
        end
        n_tests++;
        if (first_err !== 1'b0 || first_rdata !== ml) begin
            n_fail++;
            $display("FAIL bp_read_data: err=%b rdata=%h, required err=0 rdata=%h", first_err, first_rdata, ml);
        end
        n_tests++;
        if (c2_second !== C2_WRITE_LINE) begin
            n_fail++;
            $display("FAIL bp_second_cmd: C2=%h, required %h", c2_second, C2_WRITE_LINE);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(1'b1, 15'h2AAA, rand_line());
        repeat (4) @(negedge clk);
        RESET = 1'b1;
        @(negedge clk);
        model_rdata = '0;
        n_tests++;
        if (C2 !== C2_NOP || D2 !== REL_D2 || A2 !== REL_A2) begin
            n_fail++;
            $display("FAIL rstmid_bus: C2=%h A2=%h D2=%h, required %h/%h/%h", C2, A2, D2, C2_NOP, REL_A2, REL_D2);
        end
        n_tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: ready=%b valid=%b, required 1/0", req_ready, resp_valid);
        end
        RESET  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_resp: %0d resp cycles, required 0", pulses);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        RESET     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_line  = '0;
        req_wdata = '0;
        mem_delay = 0;
        mem_line  = '0;
        model_rdata = '0;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
